gearbox_fifo_pkt: RTL and testbench

//  Parametrised width-converting FIFO. Handles down-conversion (IDATA_WIDTH > ODATA_WIDTH)
//  and up-conversion (IDATA_WIDTH < ODATA_WIDTH). Packet boundaries carried via last flag,
//  so partial output words drain on end-of-packet. Sits between narrow and wide datapath

---
 rtl/gearbox_fifo_pkt.sv | 123 ++++++++++++
 tb/tb_gearbox_fifo_pkt.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_fifo_pkt.sv
// Width-converting packet FIFO: stores UNIT-wide slices so one storage array serves
// both up- and down-conversion; last flags let partial output words drain at end of packet.
module gearbox_fifo_pkt #(
  parameter int IDATA_WIDTH = 64,
  parameter int ODATA_WIDTH = 16,
  parameter int DEPTH       = 16,
  parameter int AE_LEVEL    = 4,
  parameter int AF_LEVEL    = 4,
  localparam int UNIT = (IDATA_WIDTH < ODATA_WIDTH) ? IDATA_WIDTH : ODATA_WIDTH,
  localparam int RI   = IDATA_WIDTH / UNIT,
  localparam int RO   = ODATA_WIDTH / UNIT,
  localparam int RMAX = (RI > RO) ? RI : RO,
  localparam int CAP  = DEPTH * RMAX,
  localparam int PW   = $clog2(CAP),
  localparam int LW   = $clog2(CAP + 1),
  localparam int VW   = $clog2(RO + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_req_in,
  input  logic                   push_last_in,
  input  logic [IDATA_WIDTH-1:0] data_in,
  output logic                   full_out,
  output logic                   almost_full_out,
  input  logic                   pop_req_in,
  output logic [ODATA_WIDTH-1:0] data_out,
  output logic                   last_out,
  output logic [VW-1:0]          valid_units_out,
  output logic                   empty_out,
  output logic                   almost_empty_out,
  output logic [LW-1:0]          level_out,
  input  logic                   error_clr_in,
  output logic                   error_out
);

  logic [UNIT-1:0]        mem_q [CAP];
  logic [CAP-1:0]         last_mem_q;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d, last_cnt_q, last_cnt_d;
  logic                   error_q, error_d;

  logic                   full, empty, push_ok, pop_ok;
  logic                   found;
  logic [VW-1:0]          k;
  logic [PW-1:0]          idx;
  logic [ODATA_WIDTH-1:0] word;

  // Flags come purely from registered level/last-count.
  always_comb begin
    full             = (LW'(CAP) - level_q) < LW'(RI);
    empty            = (level_q < LW'(RO)) && (last_cnt_q == '0);
    full_out         = full;
    empty_out        = empty;
    almost_full_out  = level_q >= LW'(CAP - AF_LEVEL);
    almost_empty_out = level_q <= LW'(AE_LEVEL);
    level_out        = level_q;
    error_out        = error_q;
  end

  // Output word length K: stops at the first stored last flag within the head RO units.
  always_comb begin
    found = 1'b0;
    k     = VW'(RO);
    word  = '0;
    idx   = '0;
    for (int i = 0; i < RO; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (!found && (LW'(i) < level_q) && last_mem_q[idx]) begin
        found = 1'b1;
        k     = VW'(i + 1);
      end
    end
    for (int i = 0; i < RO; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (VW'(i) < k) word[i*UNIT +: UNIT] = mem_q[idx];
    end
    data_out        = empty ? '0 : word;
    last_out        = !empty && found;
    valid_units_out = empty ? '0 : k;
  end

  always_comb begin
    push_ok    = push_req_in && !full;
    pop_ok     = pop_req_in && !empty;
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(RI) : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + PW'(k) : rd_ptr_q;
    level_d    = level_q + (push_ok ? LW'(RI) : '0) - (pop_ok ? LW'(k) : '0);
    last_cnt_d = last_cnt_q + LW'(push_ok && push_last_in) - LW'(pop_ok && found);
    error_d    = error_q;
    if (error_clr_in) error_d = 1'b0;
    // A fresh error in the same cycle takes priority over the clear.
    if ((push_req_in && full) || (pop_req_in && empty)) error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_cnt_q <= last_cnt_d;
      error_q    <= error_d;
    end
  end

  // NOTE: storage is deliberately not reset; level/last-count gate every read, so stale
  // contents can never reach the outputs and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < RI; i++) begin
        mem_q[wr_ptr_q + PW'(i)]      <= data_in[i*UNIT +: UNIT];
        last_mem_q[wr_ptr_q + PW'(i)] <= push_last_in && (i == RI - 1);
      end
    end
  end

endmodule

// File: tb/tb_gearbox_fifo_pkt.sv
// Directed bench for gearbox_fifo_pkt: one down-converting (64->16) and one
// up-converting (16->64) instance, each checked against a unit-level scoreboard.
module tb_gearbox_fifo_pkt;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [2:0]  vu;
  } exp_t;

  logic clk, rst;

  logic        dn_push, dn_last, dn_full, dn_af, dn_pop, dn_lout, dn_empty, dn_ae, dn_clr, dn_err;
  logic [63:0] dn_din;
  logic [15:0] dn_dout;
  logic [0:0]  dn_vu;
  logic [6:0]  dn_level;

  logic        up_push, up_last, up_full, up_af, up_pop, up_lout, up_empty, up_ae, up_clr, up_err;
  logic [15:0] up_din;
  logic [63:0] up_dout;
  logic [2:0]  up_vu;
  logic [6:0]  up_level;

  int vectors = 0;
  int miscompares = 0;

  exp_t        dn_q[$];
  exp_t        up_q[$];
  logic [63:0] up_acc = '0;
  int          up_cnt = 0;

  gearbox_fifo_pkt #(.IDATA_WIDTH(64), .ODATA_WIDTH(16)) u_dn (
    .clk(clk), .rst(rst),
    .push_req_in(dn_push), .push_last_in(dn_last), .data_in(dn_din),
    .full_out(dn_full), .almost_full_out(dn_af),
    .pop_req_in(dn_pop), .data_out(dn_dout), .last_out(dn_lout),
    .valid_units_out(dn_vu), .empty_out(dn_empty), .almost_empty_out(dn_ae),
    .level_out(dn_level), .error_clr_in(dn_clr), .error_out(dn_err)
  );

  gearbox_fifo_pkt #(.IDATA_WIDTH(16), .ODATA_WIDTH(64)) u_up (
    .clk(clk), .rst(rst),
    .push_req_in(up_push), .push_last_in(up_last), .data_in(up_din),
    .full_out(up_full), .almost_full_out(up_af),
    .pop_req_in(up_pop), .data_out(up_dout), .last_out(up_lout),
    .valid_units_out(up_vu), .empty_out(up_empty), .almost_empty_out(up_ae),
    .level_out(up_level), .error_clr_in(up_clr), .error_out(up_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int up_units();
    int n = up_cnt;
    foreach (up_q[i]) n += int'(up_q[i].vu);
    return n;
  endfunction

  // Accepted iff at least 4 free units remain (capacity 64 units).
  task automatic dn_push_word(input logic [63:0] w, input logic l);
    exp_t e;
    dn_push = 1'b1; dn_last = l; dn_din = w;
    if (dn_q.size() <= 60) begin
      for (int i = 0; i < 4; i++) begin
        e.data = {48'h0, w[i*16 +: 16]};
        e.last = l && (i == 3);
        e.vu   = 3'd1;
        dn_q.push_back(e);
      end
    end
    tick();
    dn_push = 1'b0; dn_last = 1'b0;
  endtask

  task automatic dn_pop_check(input string tag);
    if (dn_q.size() == 0) begin
      check({tag, "_sb_underrun"}, 64'(dn_empty), 64'd0);
    end else begin
      check({tag, "_data"}, 64'(dn_dout), dn_q[0].data);
      check({tag, "_last"}, 64'(dn_lout), 64'(dn_q[0].last));
      check({tag, "_vu"},   64'(dn_vu),   64'(dn_q[0].vu));
      dn_pop = 1'b1;
      tick();
      dn_pop = 1'b0;
      void'(dn_q.pop_front());
      check({tag, "_level"}, 64'(dn_level), 64'(dn_q.size()));
    end
  endtask

  task automatic up_push_word(input logic [15:0] w, input logic l);
    exp_t e;
    up_push = 1'b1; up_last = l; up_din = w;
    up_acc[up_cnt*16 +: 16] = w;
    up_cnt++;
    if (up_cnt == 4 || l) begin
      e.data = up_acc; e.last = l; e.vu = 3'(up_cnt);
      up_q.push_back(e);
      up_acc = '0; up_cnt = 0;
    end
    tick();
    up_push = 1'b0; up_last = 1'b0;
  endtask

  task automatic up_pop_check(input string tag);
    if (up_q.size() == 0) begin
      check({tag, "_sb_underrun"}, 64'(up_empty), 64'd0);
    end else begin
      check({tag, "_data"}, up_dout, up_q[0].data);
      check({tag, "_last"}, 64'(up_lout), 64'(up_q[0].last));
      check({tag, "_vu"},   64'(up_vu),   64'(up_q[0].vu));
      up_pop = 1'b1;
      tick();
      up_pop = 1'b0;
      void'(up_q.pop_front());
      check({tag, "_level"}, 64'(up_level), 64'(up_units()));
    end
  endtask

  initial begin
    rst = 1'b1;
    dn_push = 0; dn_last = 0; dn_din = '0; dn_pop = 0; dn_clr = 0;
    up_push = 0; up_last = 0; up_din = '0; up_pop = 0; up_clr = 0;
    #2;
    check("rst_dn_empty", 64'(dn_empty), 64'd1);
    check("rst_dn_ae",    64'(dn_ae),    64'd1);
    check("rst_dn_full",  64'(dn_full),  64'd0);
    check("rst_dn_af",    64'(dn_af),    64'd0);
    check("rst_dn_err",   64'(dn_err),   64'd0);
    check("rst_dn_level", 64'(dn_level), 64'd0);
    check("rst_dn_data",  64'(dn_dout),  64'd0);
    check("rst_up_empty", 64'(up_empty), 64'd1);
    check("rst_up_data",  up_dout,       64'd0);
    check("rst_up_vu",    64'(up_vu),    64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: one 64-bit word splits into four 16-bit units
    dn_push_word(64'h0003_0002_0001_0000, 1'b0);
    check("t1_level", 64'(dn_level), 64'd4);
    check("t1_ae",    64'(dn_ae),    64'd1);
    for (int i = 0; i < 4; i++) dn_pop_check("t1_pop");
    check("t1_empty", 64'(dn_empty), 64'd1);

    // pop while empty raises error; clear; new error beats same-cycle clear
    dn_pop = 1'b1; tick(); dn_pop = 1'b0;
    check("uf_err", 64'(dn_err), 64'd1);
    check("uf_level", 64'(dn_level), 64'd0);
    dn_clr = 1'b1; tick(); dn_clr = 1'b0;
    check("uf_clr", 64'(dn_err), 64'd0);
    dn_clr = 1'b1; dn_pop = 1'b1; tick(); dn_clr = 1'b0; dn_pop = 1'b0;
    check("uf_err_wins", 64'(dn_err), 64'd1);
    dn_clr = 1'b1; tick(); dn_clr = 1'b0;
    check("uf_clr2", 64'(dn_err), 64'd0);

    // 2: four narrow words assemble one wide word
    up_push_word(16'h000A, 1'b0);
    up_push_word(16'h000B, 1'b0);
    up_push_word(16'h000C, 1'b0);
    check("t2_empty_3", 64'(up_empty), 64'd1);
    up_push_word(16'h000D, 1'b0);
    check("t2_empty_4", 64'(up_empty), 64'd0);
    check("t2_data_const", up_dout, 64'h000D_000C_000B_000A);
    up_pop_check("t2_pop");
    check("t2_empty_end", 64'(up_empty), 64'd1);

    // 3: last flag flushes a partial wide word
    up_push_word(16'h0011, 1'b0);
    up_push_word(16'h0022, 1'b1);
    check("t3_data_const", up_dout, 64'h0000_0000_0022_0011);
    up_pop_check("t3_pop");
    check("t3_empty", 64'(up_empty), 64'd1);

    // 4: fill to full, overflow, clear
    for (int i = 0; i < 16; i++) begin
      dn_push_word({16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)}, (i % 3) == 2);
      if (i == 1)  check("t4_ae_off", 64'(dn_ae), 64'd0);
      if (i == 14) check("t4_full_60", 64'(dn_full), 64'd0);
      if (i == 14) check("t4_af_60",   64'(dn_af),   64'd1);
    end
    check("t4_full",  64'(dn_full),  64'd1);
    check("t4_level", 64'(dn_level), 64'd64);
    dn_push_word(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check("t4_ovf_err",   64'(dn_err),   64'd1);
    check("t4_ovf_level", 64'(dn_level), 64'(dn_q.size()));
    dn_clr = 1'b1; tick(); dn_clr = 1'b0;
    check("t4_clr", 64'(dn_err), 64'd0);

    // 5: push+pop at full: push rejected, pop taken
    check("t5_data", 64'(dn_dout), dn_q[0].data);
    dn_push = 1'b1; dn_din = 64'h1111_2222_3333_4444; dn_pop = 1'b1;
    tick();
    dn_push = 1'b0; dn_pop = 1'b0;
    void'(dn_q.pop_front());
    check("t5_level", 64'(dn_level), 64'd63);
    check("t5_err",   64'(dn_err),   64'd1);

    // drain to level 20, checking every unit including last flags
    while (dn_q.size() > 20) dn_pop_check("drain");

    // 6: async reset mid-stream discards everything
    rst = 1'b1;
    #1;
    check("t6_level", 64'(dn_level), 64'd0);
    check("t6_empty", 64'(dn_empty), 64'd1);
    check("t6_data",  64'(dn_dout),  64'd0);
    check("t6_last",  64'(dn_lout),  64'd0);
    check("t6_vu",    64'(dn_vu),    64'd0);
    check("t6_err",   64'(dn_err),   64'd0);
    check("t6_af",    64'(dn_af),    64'd0);
    dn_q.delete();
    tick();
    rst = 1'b0;
    tick();
    dn_push_word(64'h0000_0000_0000_0005, 1'b0);
    check("t6_first", 64'(dn_dout), 64'h5);
    for (int i = 0; i < 4; i++) dn_pop_check("t6_pop");
    check("t6_empty_end", 64'(dn_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
